// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller: request lengths, FSM states,
// bus owners and the default IO window base.
package mem_ctrl_pkg;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  localparam logic [31:0] MEM_IO_BASE = 32'h0003_0000;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  typedef enum logic {
    OWN_LSB,
    OWN_IF
  } owner_t;

  // Unknown length code 11 falls through to a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serialises LSB load/store and instruction-fetch requests onto the 8-bit
// external RAM bus, one byte per cycle, little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(MEM_IO_BASE),
  parameter int unsigned           IO_SPAN    = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  lsb_signal,
  input  logic                  lsb_wr,
  input  logic [1:0]            lsb_len,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [31:0]           lsb_din,
  output logic [31:0]           lsb_dout,
  output logic                  lsb_done,
  input  logic                  if_signal,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_dout,
  output logic                  if_done,
  input  logic                  clear_signal,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr,
  input  logic                  io_buffer_full
);

  state_t                  state_q, state_d;
  owner_t                  owner_q, owner_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              len_q, len_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic                    lsb_done_q, if_done_q;

  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic                    io_hit;
  logic                    last;
  logic                    xfer_done;
  logic [31:0]             rd_merge;

  assign cur_addr = addr_q + ADDR_WIDTH'(cnt_q);
  assign io_hit   = (cur_addr - IO_BASE) < ADDR_WIDTH'(IO_SPAN);
  assign last     = (cnt_q == len_q);

  // RAM data lags its address by one cycle, so the byte on ram_din now
  // belongs to slot cnt-1; the final byte is merged combinationally so the
  // result is ready in the done cycle.
  always_comb begin
    rd_merge = data_q;
    case (cnt_q)
      3'd1:    rd_merge[7:0]   = ram_din;
      3'd2:    rd_merge[15:8]  = ram_din;
      3'd3:    rd_merge[23:16] = ram_din;
      3'd4:    rd_merge[31:24] = ram_din;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    data_d    = data_q;
    xfer_done = 1'b0;
    ram_wr    = 1'b0;
    ram_a     = '0;
    ram_dout  = '0;

    case (state_q)
      IDLE: begin
        // A requester keeps its signal up for one cycle after done; the
        // registered done flags keep that stale request from re-entering.
        if (rdy_in && !clear_signal) begin
          if (lsb_signal && !lsb_done_q) begin
            owner_d = OWN_LSB;
            state_d = lsb_wr ? WRITE : READ;
            len_d   = len_bytes(lsb_len);
            addr_d  = lsb_addr;
            data_d  = lsb_wr ? lsb_din : '0;
            cnt_d   = '0;
          end else if (if_signal && !if_done_q) begin
            owner_d = OWN_IF;
            state_d = READ;
            len_d   = 3'd4;
            addr_d  = if_addr;
            data_d  = '0;
            cnt_d   = '0;
          end
        end
      end

      READ: begin
        if (!last) ram_a = cur_addr;
        if (rdy_in) begin
          if (clear_signal) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (last) begin
            xfer_done = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            data_d = rd_merge;
            cnt_d  = cnt_q + 3'd1;
          end
        end
      end

      WRITE: begin
        if (last) begin
          if (rdy_in) begin
            xfer_done = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end
        end else begin
          ram_a = cur_addr;
          case (cnt_q)
            3'd0:    ram_dout = data_q[7:0];
            3'd1:    ram_dout = data_q[15:8];
            3'd2:    ram_dout = data_q[23:16];
            default: ram_dout = data_q[31:24];
          endcase
          if (!(io_hit && io_buffer_full)) begin
            ram_wr = rdy_in;
            if (rdy_in) cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign lsb_done = xfer_done && (owner_q == OWN_LSB);
  assign if_done  = xfer_done && (owner_q == OWN_IF);
  assign lsb_dout = (lsb_done && state_q == READ) ? rd_merge : '0;
  assign if_dout  = if_done ? rd_merge : '0;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      owner_q    <= OWN_LSB;
      cnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      lsb_done_q <= 1'b0;
      if_done_q  <= 1'b0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      lsb_done_q <= lsb_done;
      if_done_q  <= if_done;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle-latency RAM model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        lsb_signal;
  logic        lsb_wr;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_din;
  logic [31:0] lsb_dout;
  logic        lsb_done;
  logic        if_signal;
  logic [31:0] if_addr;
  logic [31:0] if_dout;
  logic        if_done;
  logic        clear_signal;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_buffer_full;

  logic [7:0]  mem [256];
  int          n_assert = 0;
  int          n_fail   = 0;

  mem_ctrl #(
    .ADDR_WIDTH(32),
    .IO_BASE   (32'h0003_0000),
    .IO_SPAN   (8)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .lsb_signal    (lsb_signal),
    .lsb_wr        (lsb_wr),
    .lsb_len       (lsb_len),
    .lsb_addr      (lsb_addr),
    .lsb_din       (lsb_din),
    .lsb_dout      (lsb_dout),
    .lsb_done      (lsb_done),
    .if_signal     (if_signal),
    .if_addr       (if_addr),
    .if_dout       (if_dout),
    .if_done       (if_done),
    .clear_signal  (clear_signal),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout),
    .ram_a         (ram_a),
    .ram_wr        (ram_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // RAM: data for the address presented in one cycle appears the next.
  always @(posedge clk_in) ram_din <= mem[ram_a[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_a"},    ram_a,    32'h0);
    chk({tag, "_wr"},   {31'b0, ram_wr},   32'h0);
    chk({tag, "_ldn"},  {31'b0, lsb_done}, 32'h0);
    chk({tag, "_idn"},  {31'b0, if_done},  32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    mem[8'h05] = 8'h5A; mem[8'h06] = 8'h66;
    mem[8'h10] = 8'h13; mem[8'h11] = 8'h00; mem[8'h12] = 8'h50; mem[8'h13] = 8'h93;

    rst_in = 1'b0; rdy_in = 1'b1; clear_signal = 1'b0; io_buffer_full = 1'b0;
    lsb_signal = 1'b0; lsb_wr = 1'b0; lsb_len = 2'b00; lsb_addr = '0; lsb_din = '0;
    if_signal = 1'b0; if_addr = '0;

    // Reset state
    @(negedge clk_in); #1;
    chk_quiet("rst");
    chk("rst_dout", ram_dout, 32'h0);
    chk("rst_ldout", lsb_dout, 32'h0);
    chk("rst_idout", if_dout, 32'h0);
    @(negedge clk_in); rst_in = 1'b1;

    // 1: load word at 0x100
    @(negedge clk_in); lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b10; lsb_addr = 32'h100; #1;
    chk("t1_pre_a", ram_a, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in); #1;
      chk("t1_a", ram_a, 32'h100 + k);
      chk("t1_wr", {31'b0, ram_wr}, 32'h0);
      chk("t1_early", {31'b0, lsb_done}, 32'h0);
    end
    @(negedge clk_in); #1;
    chk("t1_done", {31'b0, lsb_done}, 32'h1);
    chk("t1_dout", lsb_dout, 32'h4433_2211);
    chk("t1_ifdn", {31'b0, if_done}, 32'h0);
    @(negedge clk_in); #1;
    chk_quiet("t1_hold");
    @(negedge clk_in); lsb_signal = 1'b0; #1;
    chk_quiet("t1_after");

    // 2: store half 0xBEEF to 0x202; io full must not stall a non-IO address
    @(negedge clk_in); lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'b01;
    lsb_addr = 32'h202; lsb_din = 32'h0000_BEEF; io_buffer_full = 1'b1; #1;
    @(negedge clk_in); #1;
    chk("t2_a0", ram_a, 32'h202);
    chk("t2_d0", ram_dout, 32'hEF);
    chk("t2_w0", {31'b0, ram_wr}, 32'h1);
    @(negedge clk_in); #1;
    chk("t2_a1", ram_a, 32'h203);
    chk("t2_d1", ram_dout, 32'hBE);
    chk("t2_w1", {31'b0, ram_wr}, 32'h1);
    @(negedge clk_in); #1;
    chk("t2_done", {31'b0, lsb_done}, 32'h1);
    chk("t2_nowr", {31'b0, ram_wr}, 32'h0);
    chk("t2_ldout", lsb_dout, 32'h0);
    @(negedge clk_in); #1;
    chk_quiet("t2_hold");
    @(negedge clk_in); lsb_signal = 1'b0; io_buffer_full = 1'b0;

    // 3: simultaneous load byte and fetch
    @(negedge clk_in); lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b00; lsb_addr = 32'h105;
    if_signal = 1'b1; if_addr = 32'h10; #1;
    @(negedge clk_in); #1;
    chk("t3_lsb_a", ram_a, 32'h105);
    @(negedge clk_in); #1;
    chk("t3_ldone", {31'b0, lsb_done}, 32'h1);
    chk("t3_ldout", lsb_dout, 32'h0000_005A);
    chk("t3_idn0", {31'b0, if_done}, 32'h0);
    @(negedge clk_in); #1;
    chk_quiet("t3_gap");
    @(negedge clk_in); lsb_signal = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk_in); #1; end
      chk("t3_if_a", ram_a, 32'h10 + k);
      chk("t3_if_early", {31'b0, if_done}, 32'h0);
    end
    @(negedge clk_in); #1;
    chk("t3_idone", {31'b0, if_done}, 32'h1);
    chk("t3_idout", if_dout, 32'h9350_0013);
    chk("t3_ldn1", {31'b0, lsb_done}, 32'h0);
    @(negedge clk_in); #1;
    chk_quiet("t3_hold");
    @(negedge clk_in); if_signal = 1'b0;

    // 4a: clear during fetch byte 2, then a request blocked by clear in IDLE
    @(negedge clk_in); if_signal = 1'b1; if_addr = 32'h20; #1;
    @(negedge clk_in); #1;
    @(negedge clk_in); #1;
    chk("t4_a1", ram_a, 32'h21);
    @(negedge clk_in); clear_signal = 1'b1; if_signal = 1'b0; #1;
    chk("t4_a2", ram_a, 32'h22);
    chk("t4_nodone", {31'b0, if_done}, 32'h0);
    @(negedge clk_in); lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b00; lsb_addr = 32'h106; #1;
    chk_quiet("t4_abort");
    @(negedge clk_in); clear_signal = 1'b0; #1;
    chk_quiet("t4_clrblk");
    @(negedge clk_in); #1;
    chk("t4_ld_a", ram_a, 32'h106);
    @(negedge clk_in); #1;
    chk("t4_ld_done", {31'b0, lsb_done}, 32'h1);
    chk("t4_ld_dout", lsb_dout, 32'h66);
    @(negedge clk_in); #1;
    @(negedge clk_in); lsb_signal = 1'b0;

    // 4b: clear during store byte 1 does not kill the store
    @(negedge clk_in); lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'b10;
    lsb_addr = 32'h40; lsb_din = 32'hA1B2_C3D4; #1;
    @(negedge clk_in); #1;
    chk("t4b_d0", ram_dout, 32'hD4);
    @(negedge clk_in); clear_signal = 1'b1; #1;
    chk("t4b_a1", ram_a, 32'h41);
    chk("t4b_d1", ram_dout, 32'hC3);
    chk("t4b_w1", {31'b0, ram_wr}, 32'h1);
    @(negedge clk_in); clear_signal = 1'b0; #1;
    chk("t4b_d2", ram_dout, 32'hB2);
    @(negedge clk_in); #1;
    chk("t4b_a3", ram_a, 32'h43);
    chk("t4b_d3", ram_dout, 32'hA1);
    @(negedge clk_in); #1;
    chk("t4b_done", {31'b0, lsb_done}, 32'h1);
    @(negedge clk_in); #1;
    @(negedge clk_in); lsb_signal = 1'b0;

    // 5: IO store stalled three cycles
    @(negedge clk_in); lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'b00;
    lsb_addr = 32'h0003_0000; lsb_din = 32'h41; io_buffer_full = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in); #1;
      chk("t5_stall_wr", {31'b0, ram_wr}, 32'h0);
      chk("t5_stall_dn", {31'b0, lsb_done}, 32'h0);
    end
    @(negedge clk_in); io_buffer_full = 1'b0; #1;
    chk("t5_wr", {31'b0, ram_wr}, 32'h1);
    chk("t5_a", ram_a, 32'h0003_0000);
    chk("t5_d", ram_dout, 32'h41);
    @(negedge clk_in); #1;
    chk("t5_done", {31'b0, lsb_done}, 32'h1);
    chk("t5_nowr", {31'b0, ram_wr}, 32'h0);
    @(negedge clk_in); #1;
    @(negedge clk_in); lsb_signal = 1'b0;

    // 5b: first address past the IO window is not stalled
    @(negedge clk_in); lsb_signal = 1'b1; lsb_addr = 32'h0003_0008; io_buffer_full = 1'b1; #1;
    @(negedge clk_in); #1;
    chk("t5b_wr", {31'b0, ram_wr}, 32'h1);
    @(negedge clk_in); #1;
    chk("t5b_done", {31'b0, lsb_done}, 32'h1);
    @(negedge clk_in); #1;
    @(negedge clk_in); lsb_signal = 1'b0; io_buffer_full = 1'b0;

    // 5c: rdy_in low freezes a store and forces ram_wr low
    @(negedge clk_in); lsb_signal = 1'b1; lsb_addr = 32'h50; lsb_din = 32'h77; #1;
    @(negedge clk_in); rdy_in = 1'b0; #1;
    chk("t5c_frz_wr", {31'b0, ram_wr}, 32'h0);
    @(negedge clk_in); rdy_in = 1'b1; #1;
    chk("t5c_wr", {31'b0, ram_wr}, 32'h1);
    chk("t5c_a", ram_a, 32'h50);
    @(negedge clk_in); #1;
    chk("t5c_done", {31'b0, lsb_done}, 32'h1);
    @(negedge clk_in); #1;
    @(negedge clk_in); lsb_signal = 1'b0;

    // 6: reset mid-load, then a normal half load
    @(negedge clk_in); lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b10; lsb_addr = 32'h100; #1;
    @(negedge clk_in); #1;
    @(negedge clk_in); #1;
    chk("t6_a1", ram_a, 32'h101);
    rst_in = 1'b0; lsb_signal = 1'b0; #1;
    chk_quiet("t6_rst");
    chk("t6_ldout", lsb_dout, 32'h0);
    @(negedge clk_in); #1;
    chk_quiet("t6_rst2");
    @(negedge clk_in); rst_in = 1'b1; #1;
    @(negedge clk_in); #1;
    chk_quiet("t6_post");
    @(negedge clk_in); lsb_signal = 1'b1; lsb_len = 2'b01; lsb_addr = 32'h102; #1;
    @(negedge clk_in); #1;
    chk("t6_b_a0", ram_a, 32'h102);
    @(negedge clk_in); #1;
    chk("t6_b_a1", ram_a, 32'h103);
    @(negedge clk_in); #1;
    chk("t6_b_done", {31'b0, lsb_done}, 32'h1);
    chk("t6_b_dout", lsb_dout, 32'h0000_4433);
    @(negedge clk_in); #1;
    @(negedge clk_in); lsb_signal = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder end of the load/store request interface driven by load_store_buffer.
- Also serves the instruction-fetch request port.
- Serialises each accepted word, half or byte request onto the 8-bit external RAM bus, one byte per cycle, little-endian.
- Returns load/fetch data with a one-cycle done pulse. Sits between LSB/ifetch and the top-level RAM/IO pins.

Parameters:
ADDR_WIDTH, 32, address width of requests and RAM bus
IO_BASE, 32'h0003_0000, first byte address of the memory-mapped IO window
IO_SPAN, 8, byte size of the IO window

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous reset, active-low
rdy_in  input  1  global ready; when low all state freezes
lsb_signal  input  1  LSB request valid, held until done seen
lsb_wr  input  1  1 store, 0 load
lsb_len  input  2  00=1 byte, 01=2 bytes, 10=4 bytes
lsb_addr  input  32  byte address
lsb_din  input  32  store data (low bytes used)
lsb_dout  output  32  load data, zero-extended
lsb_done  output  1  one-cycle completion pulse
if_signal  input  1  fetch request valid, held until done
if_addr  input  32  fetch address (4-byte read)
if_dout  output  32  fetched instruction
if_done  output  1  one-cycle completion pulse
clear_signal  input  1  misprediction flush
ram_din  input  8  byte read from RAM
ram_dout  output  8  byte written to RAM
ram_a  output  32  RAM byte address
ram_wr  output  1  1 write, 0 read
io_buffer_full  input  1  IO output buffer full

Behaviour:
- Reset (rst_in low, asynchronous): state=IDLE, byte counter=0.
  - All outputs 0: lsb_done, if_done, ram_wr, ram_a, ram_dout, lsb_dout, if_dout.
  - Applies mid-transfer; the transfer is discarded.
- rdy_in low: no register updates and ram_wr forced 0; resumes exactly where it left off.
- States: IDLE, READ, WRITE. Counter cnt (3 bits), target length N = 1/2/4 from len; len=11 is treated as 4.
- Arbitration, in IDLE only:
  - An LSB request wins over fetch; a fetch is never preempted once accepted.
  - Owner is latched with addr, data and N.
  - A requester whose done is high this cycle is not re-accepted: its signal is still high for one cycle after done.
- Load/fetch of N bytes, accepted at edge t:
  - During cycles t+1..t+N: ram_a=addr+k, ram_wr=0 (k=0..N-1).
  - Byte k is sampled from ram_din one cycle after its address (RAM latency 1) into bits [8k+7:8k]; unused upper bytes are 0.
  - done asserted in cycle t+N+1 with data valid the same cycle; state back to IDLE in that cycle.
- Store of N bytes accepted at edge t:
  - During cycles t+1..t+N: ram_wr=1, ram_a=addr+k, ram_dout=din[8k+7:8k].
  - lsb_done in cycle t+N+1.
- IO stall: on a store with addr in [IO_BASE, IO_BASE+IO_SPAN) and io_buffer_full=1, hold the current byte with ram_wr=0 and cnt unchanged; resume when io_buffer_full=0.
- Idle bus: ram_wr=0 and ram_a held at 0.
- clear_signal high:
  - An in-flight READ is aborted: IDLE next cycle, no done, including LSB loads and fetches.
  - An in-flight WRITE always completes and pulses lsb_done: committed stores survive a flush.
  - A request present in IDLE the same cycle as clear is not accepted.
- done pulses are exactly one cycle, never asserted for an aborted transfer. lsb_done and if_done are never high together.
- Address arithmetic wraps modulo 2^32.

Decomposition:
- Shared package:
  - len encodings LEN_B/LEN_H/LEN_W.
  - State enum IDLE/READ/WRITE.
  - Owner enum OWN_LSB/OWN_IF.
  - IO_BASE constant.
- No sub-module needed. The byte assemble/extract logic stays inline; a single module of roughly 200 lines.

Test Plan:
- LSB load word at 0x100, RAM bytes 11,22,33,44 -> ram_a 0x100..0x103 in consecutive cycles, lsb_dout=32'h44332211, lsb_done one cycle at t+5.
- LSB store half 0x0000BEEF to 0x202 -> ram_wr=1 with (0x202,EF),(0x203,BE), lsb_done at t+3, no third write.
- LSB load and fetch raised in the same cycle -> LSB served first; fetch accepted only after the idle done cycle; if_done follows later.
- clear_signal during fetch byte 2 -> no if_done, IDLE next cycle. clear during store byte 1 -> store finishes, lsb_done pulses.
- Store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> ram_wr stays 0 for 3 cycles, then one write, then lsb_done.
- rst_in pulled low mid-load, then released -> all outputs 0, no done, next request served normally.
